// File: rtl/uart_rx_packet.sv
// Serial receiver for one WIDTH-bit LArPix frame (start, WIDTH data bits LSB first, stop).
// The frame MSB is odd parity. Good payloads go out with a one-cycle flag; bad frames are counted.
module uart_rx_packet #(
    parameter int WIDTH  = 64,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_in,
    input  logic             rx_enable,
    output logic [WIDTH-2:0] rx_data,
    output logic             rx_data_flag,
    output logic             parity_error,
    output logic             frame_error,
    output logic             rx_busy,
    output logic [7:0]       rx_error_count
);

    localparam int         IDX_W    = $clog2(WIDTH + 1);
    localparam logic [7:0] CNT_HALF = 8'(CLKDIV / 2 - 1);
    localparam logic [7:0] CNT_LAST = 8'(CLKDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state, w_state_next;
    logic               r_rx_meta, r_rxs;
    logic [7:0]         r_cnt, w_cnt_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [WIDTH-1:0]   r_sr, w_sr_next;
    logic [WIDTH-2:0]   r_rx_data;
    logic [7:0]         r_err_cnt;
    logic               r_flag, r_perr, r_ferr;
    logic               w_flag_next, w_perr_next, w_ferr_next;

    // The line idles high, so both synchroniser stages reset to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rxs     <= r_rx_meta;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_sr_next    = r_sr;
        w_flag_next  = 1'b0;
        w_perr_next  = 1'b0;
        w_ferr_next  = 1'b0;

        if (!rx_enable) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_next = '0;
                    if (!r_rxs) w_state_next = S_START;
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                        w_state_next = r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_sr_next  = {r_rxs, r_sr[WIDTH-1:1]};
                        w_idx_next = r_idx + 1'b1;
                        w_cnt_next = '0;
                        if (r_idx == IDX_W'(WIDTH - 1)) w_state_next = S_STOP;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        if (!r_rxs) begin
                            w_ferr_next  = 1'b1;
                            w_state_next = S_BREAK;
                        end else if (!(^r_sr)) begin
                            w_perr_next  = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_flag_next  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                S_BREAK: begin
                    w_cnt_next = '0;
                    if (r_rxs) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_sr      <= '0;
            r_rx_data <= '0;
            r_flag    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_sr    <= w_sr_next;
            r_flag  <= w_flag_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
            if (w_flag_next) r_rx_data <= r_sr[WIDTH-2:0];
            if ((w_perr_next || w_ferr_next) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign rx_data        = r_rx_data;
    assign rx_data_flag   = r_flag;
    assign parity_error   = r_perr;
    assign frame_error    = r_ferr;
    assign rx_error_count = r_err_cnt;
    assign rx_busy        = (r_state != S_IDLE);

endmodule
